// File: rtl/a_meas.sv
// a_meas: DFF timing-sweep measurement responder (settle, sample, vote, record).
// Define A_MEAS_SYNC_EN to pass i_q through a 2-flop synchronizer first.
module a_meas #(
  parameter int DLY_W  = 8,
  parameter int SETTLE = 4,
  parameter int NSAMP  = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_step_vld,
  input  logic [DLY_W-1:0] i_step_code,
  input  logic             i_step_edge,
  input  logic             i_step_exp,
  input  logic             i_q,
  output logic             o_busy,
  output logic             o_step_ack,
  output logic             o_step_fail,
  output logic [DLY_W-1:0] o_lh_code,
  output logic             o_lh_vld,
  output logic [DLY_W-1:0] o_hl_code,
  output logic             o_hl_vld,
  output logic             o_done
);

  localparam int EW   = $clog2(NSAMP + 1);
  localparam int CMAX = (SETTLE > NSAMP) ? SETTLE : NSAMP;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] SMP_LAST = CW'(NSAMP - 1);
  localparam logic [EW-1:0] ERR_MAX  = EW'(NSAMP);
  localparam logic [EW-1:0] HALF     = EW'(NSAMP / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_JUDGE,
    S_ACK
  } st_t;

  st_t state;
  st_t nxt;

  logic [CW-1:0]    cnt;
  logic [EW-1:0]    err_cnt;
  logic [DLY_W-1:0] code_l;
  logic             edge_l;
  logic             exp_l;
  logic             q_s;
  logic             fail_now;

`ifdef A_MEAS_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_q};
    end
  end

  assign q_s = sync_q[1];
`else
  assign q_s = i_q;
`endif

  // strict majority of mismatches fails; a tie passes
  assign fail_now = (err_cnt > HALF);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    if (i_clr) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (i_step_vld) nxt = S_SETTLE;
        S_SETTLE: if (cnt == SET_LAST) nxt = S_SAMPLE;
        S_SAMPLE: if (cnt == SMP_LAST) nxt = S_JUDGE;
        S_JUDGE:  nxt = S_ACK;
        S_ACK:    nxt = S_IDLE;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy     = (state != S_IDLE);
    o_step_ack = (state == S_ACK);
    o_done     = o_lh_vld & o_hl_vld;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt         <= '0;
      err_cnt     <= '0;
      code_l      <= '0;
      edge_l      <= 1'b0;
      exp_l       <= 1'b0;
      o_step_fail <= 1'b0;
      o_lh_code   <= '0;
      o_lh_vld    <= 1'b0;
      o_hl_code   <= '0;
      o_hl_vld    <= 1'b0;
    end else if (i_clr) begin
      cnt         <= '0;
      err_cnt     <= '0;
      o_step_fail <= 1'b0;
      o_lh_code   <= '0;
      o_lh_vld    <= 1'b0;
      o_hl_code   <= '0;
      o_hl_vld    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (i_step_vld) begin
            code_l  <= i_step_code;
            edge_l  <= i_step_edge;
            exp_l   <= i_step_exp;
            err_cnt <= '0;
          end
        end
        S_SETTLE: begin
          cnt <= (cnt == SET_LAST) ? '0 : cnt + CW'(1);
        end
        S_SAMPLE: begin
          cnt <= (cnt == SMP_LAST) ? '0 : cnt + CW'(1);
          if ((q_s != exp_l) && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + EW'(1);
          end
        end
        S_JUDGE: begin
          o_step_fail <= fail_now;
          if (fail_now && !edge_l && !o_lh_vld) begin
            o_lh_code <= code_l;
            o_lh_vld  <= 1'b1;
          end
          if (fail_now && edge_l && !o_hl_vld) begin
            o_hl_code <= code_l;
            o_hl_vld  <= 1'b1;
          end
        end
        S_ACK: begin
          cnt <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a_meas.sv
// tb_a_meas: directed steps against a cycle-indexed behavioural model of a_meas.
// Honours A_MEAS_SYNC_EN to model the synchronizer delay on i_q.
module tb_a_meas;

  localparam int SETTLE = 4;
  localparam int NSAMP  = 8;
  localparam int LAT    = SETTLE + NSAMP + 2;
`ifdef A_MEAS_SYNC_EN
  localparam int QD = 2;
  localparam logic T6_EXP = 1'b1;
`else
  localparam int QD = 0;
  localparam logic T6_EXP = 1'b0;
`endif
  // first i_q interval (relative to the vld interval) that feeds the vote
  localparam int WIN = 1 + SETTLE - QD;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clr = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] code = 8'h00;
  logic       edg = 1'b0;
  logic       ex = 1'b0;
  logic       q = 1'b0;

  logic       busy, ack, sfail, lh_vld, hl_vld, done;
  logic [7:0] lh_code, hl_code;

  a_meas #(.DLY_W(8), .SETTLE(SETTLE), .NSAMP(NSAMP)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_clr       (clr),
    .i_step_vld  (vld),
    .i_step_code (code),
    .i_step_edge (edg),
    .i_step_exp  (ex),
    .i_q         (q),
    .o_busy      (busy),
    .o_step_ack  (ack),
    .o_step_fail (sfail),
    .o_lh_code   (lh_code),
    .o_lh_vld    (lh_vld),
    .o_hl_code   (hl_code),
    .o_hl_vld    (hl_vld),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int last_ack = -1;
  int last_v = 0;

  logic       qh [0:4095];
  bit         m_act = 0;
  int         m_v = 0;
  logic [7:0] m_code = 0;
  logic       m_edge = 0, m_exp = 0;
  logic [7:0] m_lhc = 0, m_hlc = 0;
  bit         m_lhv = 0, m_hlv = 0, m_fail = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
    end
  endtask

  // model: interval k outputs depend on inputs of intervals < k
  always @(negedge clk) begin
    bit eb, ea;
    int mism;
    qh[cyc % 4096] = q;
    if (!rstn) begin
      m_act = 0; m_lhc = 0; m_hlc = 0;
      m_lhv = 0; m_hlv = 0; m_fail = 0;
    end else if (m_act && cyc == m_v + LAT) begin
      mism = 0;
      for (int i = 0; i < NSAMP; i++)
        if (qh[(m_v + WIN + i) % 4096] !== m_exp) mism++;
      m_fail = (mism > NSAMP / 2);
      if (m_fail && !m_edge && !m_lhv) begin m_lhv = 1; m_lhc = m_code; end
      if (m_fail && m_edge && !m_hlv) begin m_hlv = 1; m_hlc = m_code; end
    end
    eb = m_act && (cyc <= m_v + LAT);
    ea = m_act && (cyc == m_v + LAT);
    chk("busy", busy, eb);
    chk("ack", ack, ea);
    chk("step_fail", sfail, m_fail);
    chk("lh_vld", lh_vld, m_lhv);
    chk("lh_code", lh_code, m_lhc);
    chk("hl_vld", hl_vld, m_hlv);
    chk("hl_code", hl_code, m_hlc);
    chk("done", done, m_lhv & m_hlv);
    if (ack === 1'b1) begin ack_cnt++; last_ack = cyc; end
    if (rstn) begin
      if (clr) begin
        m_act = 0; m_lhc = 0; m_hlc = 0;
        m_lhv = 0; m_hlv = 0; m_fail = 0;
      end else if (vld && !eb) begin
        m_act = 1; m_v = cyc;
        m_code = code; m_edge = edg; m_exp = ex;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [16:0] mm_of(input logic [7:0] pat);
    logic [16:0] m;
    m = 17'(pat);
    return m << WIN;
  endfunction

  // mm bit j = i_q mismatches exp in interval v+j
  task automatic step(input logic [7:0] c, input logic e, input logic x,
                      input logic [16:0] mm, input bit rep);
    tick();
    vld = 1'b1; code = c; edg = e; ex = x;
    q = mm[0] ? ~x : x;
    last_v = cyc;
    for (int j = 1; j <= 16; j++) begin
      tick();
      vld = rep && (j == 3 || j == 14);
      q = mm[j] ? ~x : x;
    end
    tick();
    vld = 1'b0;
    chk("latency", 32'(last_ack - last_v), 32'(LAT));
  endtask

  initial begin
    int a0;
    repeat (3) tick();
    rstn = 1'b1;
    repeat (3) tick();

    a0 = ack_cnt;
    step(8'h10, 1'b0, 1'b1, mm_of(8'h00), 0);
    chk("t2_fail", sfail, 0);
    chk("t2_lh_vld", lh_vld, 0);
    chk("t2_one_ack", 32'(ack_cnt - a0), 1);

    step(8'h23, 1'b0, 1'b1, mm_of(8'b0001_1111), 0);
    chk("t3_fail", sfail, 1);
    chk("t3_lh_code", lh_code, 8'h23);
    chk("t3_lh_vld", lh_vld, 1);
    step(8'h24, 1'b0, 1'b1, mm_of(8'hFF), 0);
    chk("t3_keep_code", lh_code, 8'h23);

    step(8'h30, 1'b1, 1'b0, mm_of(8'b1010_1010), 0);
    chk("t4_tie_pass", sfail, 0);
    chk("t4_hl_vld0", hl_vld, 0);
    step(8'h00, 1'b1, 1'b0, mm_of(8'hFF), 0);
    chk("t4_hl_code", hl_code, 8'h00);
    chk("t4_hl_vld", hl_vld, 1);
    chk("t4_done", done, 1);

    a0 = ack_cnt;
    step(8'h40, 1'b0, 1'b1, mm_of(8'h00), 1);
    chk("t5_one_ack", 32'(ack_cnt - a0), 1);
    a0 = ack_cnt;
    tick();
    clr = 1'b1; vld = 1'b1; code = 8'h55;
    tick();
    clr = 1'b0; vld = 1'b0;
    repeat (16) tick();
    chk("t5_no_ack", 32'(ack_cnt - a0), 0);
    chk("t5_lh_vld", lh_vld, 0);
    chk("t5_hl_vld", hl_vld, 0);

    step(8'h50, 1'b0, 1'b1, 17'b0_0000_0000_1111_1000, 0);
    chk("t6_boundary", sfail, T6_EXP);

    step(8'h61, 1'b1, 1'b0, mm_of(8'hFF), 0);
    chk("t1_pre_hl", hl_vld, 1);
    tick();
    vld = 1'b1; code = 8'h62; edg = 1'b1; ex = 1'b0; q = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      vld = 1'b0;
    end
    rstn = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_ack", ack, 0);
    chk("t1_fail", sfail, 0);
    chk("t1_hl_vld", hl_vld, 0);
    chk("t1_hl_code", hl_code, 0);
    chk("t1_done", done, 0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    step(8'h70, 1'b0, 1'b1, mm_of(8'b0111_0111), 0);
    chk("t1_after_fail", sfail, 1);
    chk("t1_after_code", lh_code, 8'h70);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
